// File: rtl/stopwatch_display_ctrl.sv
// stopwatch_display_ctrl
//
// Stopwatch controller for a VGA MM:SS.cc display. It owns the start/pause/clear
// state machine and the centisecond BCD count. It snapshots the count once per
// frame and maps each streamed pixel coordinate onto one of six 40x80 digit slots
// (order m1,m0,s1,s0,c1,c0) for a shared combinational glyph renderer.
//
// Optional feature macro: STOPWATCH_LAP_EN
//   When defined, a lap pulse in RUN toggles a freeze flag that stops the
//   per-frame snapshot load while counting continues. When undefined, lap is
//   ignored.
//
// Ports:
//   clk          pixel/system clock
//   rst          asynchronous active-high reset
//   start_stop   one-cycle pulse: IDLE->RUN, RUN->PAUSE, PAUSE->RUN
//   clear        one-cycle pulse: PAUSE->IDLE (wins over start_stop)
//   lap          one-cycle pulse: freeze toggle (STOPWATCH_LAP_EN only)
//   frame_start  one-cycle pulse at start of vertical blanking
//   hcnt, vcnt   current pixel column/row
//   glyph_x/y    slot-local coordinate (registered, one cycle latency)
//   glyph_d      digit code for the slot, 4'hF outside all slots
//   glyph_en     pixel lies inside a digit box
//   running      high while in RUN
//   time_bcd     live count {m1,m0,s1,s0,c1,c0}

module stopwatch_display_ctrl #(
  parameter int CLK_HZ   = 25000000,
  parameter int TICK_HZ  = 100,
  parameter int ORIGIN_X = 100,
  parameter int ORIGIN_Y = 200,
  parameter int PITCH    = 48
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_stop,
  input  logic        clear,
  input  logic        lap,
  input  logic        frame_start,
  input  logic [9:0]  hcnt,
  input  logic [9:0]  vcnt,
  output logic [9:0]  glyph_x,
  output logic [9:0]  glyph_y,
  output logic [3:0]  glyph_d,
  output logic        glyph_en,
  output logic        running,
  output logic [23:0] time_bcd
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

  localparam logic [11:0] Y_LO = 12'(ORIGIN_Y);
  localparam logic [11:0] Y_HI = 12'(ORIGIN_Y + 79);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic            to_idle;
  logic            tick;
  logic [PW-1:0]   presc;
  logic [23:0]     time_q;
  logic [23:0]     snap;
  logic            freeze;

  logic [11:0]     h_ext;
  logic [11:0]     v_ext;
  logic            in_rows;
  logic            hit;
  logic [9:0]      x_next;
  logic [9:0]      y_next;
  logic [3:0]      d_next;

  // Increment a {m1,m0,s1,s0,c1,c0} BCD value with ripple carry; the tens
  // digits of seconds and minutes roll over at 5, so 59:59.99 wraps to zero.
  function automatic logic [23:0] bcd_inc(input logic [23:0] t);
    logic [23:0] r;
    logic        carry;
    logic [3:0]  lim;
    r     = t;
    carry = 1'b1;
    for (int i = 0; i < 6; i++) begin
      lim = (i == 3 || i == 5) ? 4'd5 : 4'd9;
      if (carry) begin
        if (r[4*i +: 4] == lim) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Clear beats start_stop in PAUSE; clear is ignored in RUN and IDLE.
  always_comb begin
    state_next = state;
    to_idle    = 1'b0;
    case (state)
      IDLE: begin
        if (start_stop) state_next = RUN;
      end
      RUN: begin
        if (start_stop) state_next = PAUSE;
      end
      PAUSE: begin
        if (clear) begin
          state_next = IDLE;
          to_idle    = 1'b1;
        end else if (start_stop) begin
          state_next = RUN;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // The prescaler advances whenever the current state is RUN, including the
  // cycle in which a pause is requested; it holds in PAUSE so a resume keeps
  // the partial centisecond.
  assign tick = (state == RUN) && (presc == PRESC_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
    end else if (to_idle) begin
      presc <= '0;
    end else if (state == RUN) begin
      if (presc == PRESC_MAX) begin
        presc <= '0;
      end else begin
        presc <= presc + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      time_q <= 24'h000000;
    end else if (to_idle) begin
      time_q <= 24'h000000;
    end else if (tick) begin
      time_q <= bcd_inc(time_q);
    end
  end

`ifdef STOPWATCH_LAP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      freeze <= 1'b0;
    end else if (to_idle) begin
      freeze <= 1'b0;
    end else if (lap && state == RUN) begin
      freeze <= ~freeze;
    end
  end
`else
  logic unused_lap;
  assign unused_lap = lap;
  assign freeze     = 1'b0;
`endif

  // The snapshot samples the registered count, so a tick on the same edge
  // leaves the pre-tick value in the snapshot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap <= 24'h000000;
    end else if (frame_start && !freeze) begin
      snap <= time_q;
    end
  end

  assign h_ext   = {2'b00, hcnt};
  assign v_ext   = {2'b00, vcnt};
  assign in_rows = (v_ext >= Y_LO) && (v_ext <= Y_HI);

  // Slots never overlap (PITCH >= 40), so at most one bound check matches.
  // The loop unrolls into constant comparisons; no division is involved.
  always_comb begin
    hit    = 1'b0;
    x_next = 10'd0;
    y_next = 10'd0;
    d_next = 4'hF;
    for (int k = 0; k < 6; k++) begin
      if (in_rows &&
          h_ext >= 12'(ORIGIN_X + k * PITCH) &&
          h_ext <= 12'(ORIGIN_X + k * PITCH + 39)) begin
        hit    = 1'b1;
        x_next = 10'(h_ext - 12'(ORIGIN_X + k * PITCH));
        y_next = 10'(v_ext - Y_LO);
        d_next = snap[23 - 4*k -: 4];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      glyph_en <= 1'b0;
      glyph_x  <= 10'd0;
      glyph_y  <= 10'd0;
      glyph_d  <= 4'hF;
    end else begin
      glyph_en <= hit;
      glyph_x  <= x_next;
      glyph_y  <= y_next;
      glyph_d  <= d_next;
    end
  end

  assign running  = (state == RUN);
  assign time_bcd = time_q;

endmodule

// File: tb/tb_stopwatch_display_ctrl.sv
// tb_stopwatch_display_ctrl
//
// Directed bench for stopwatch_display_ctrl with a 10-cycle prescaler
// (CLK_HZ=1000, TICK_HZ=100). Expected values are hand-computed edge counts.

module tb_stopwatch_display_ctrl;

  logic        clk;
  logic        rst;
  logic        start_stop;
  logic        clear;
  logic        lap;
  logic        frame_start;
  logic [9:0]  hcnt;
  logic [9:0]  vcnt;
  logic [9:0]  glyph_x;
  logic [9:0]  glyph_y;
  logic [3:0]  glyph_d;
  logic        glyph_en;
  logic        running;
  logic [23:0] time_bcd;

  logic [31:0] gobs;
  int          checkCount;
  int          passCount;

  stopwatch_display_ctrl #(
    .CLK_HZ   (1000),
    .TICK_HZ  (100),
    .ORIGIN_X (100),
    .ORIGIN_Y (200),
    .PITCH    (48)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start_stop  (start_stop),
    .clear       (clear),
    .lap         (lap),
    .frame_start (frame_start),
    .hcnt        (hcnt),
    .vcnt        (vcnt),
    .glyph_x     (glyph_x),
    .glyph_y     (glyph_y),
    .glyph_d     (glyph_d),
    .glyph_en    (glyph_en),
    .running     (running),
    .time_bcd    (time_bcd)
  );

  assign gobs = {7'b0, glyph_en, glyph_x, glyph_y, glyph_d};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] gexp(input logic en, input int x, input int y,
                                       input logic [3:0] d);
    return {7'b0, en, 10'(x), 10'(y), d};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    checkCount++;
    if (got === exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Holds the given pulses for exactly one active edge.
  task automatic applyStimulus(input logic ss, input logic clr, input logic lp,
                               input logic fs);
    start_stop  = ss;
    clear       = clr;
    lap         = lp;
    frame_start = fs;
    step(1);
    start_stop  = 1'b0;
    clear       = 1'b0;
    lap         = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic glyphAt(input string tag, input int h, input int v,
                         input logic [31:0] exp);
    hcnt = 10'(h);
    vcnt = 10'(v);
    step(1);
    checkOutput(tag, gobs, exp);
  endtask

  initial begin
    checkCount  = 0;
    passCount   = 0;
    rst         = 1'b1;
    start_stop  = 1'b0;
    clear       = 1'b0;
    lap         = 1'b0;
    frame_start = 1'b0;
    hcnt        = 10'd100;
    vcnt        = 10'd200;

    #22;
    checkOutput("reset_running", {31'b0, running}, 32'd0);
    checkOutput("reset_time", {8'b0, time_bcd}, 32'h000000);
    checkOutput("reset_glyph", gobs, gexp(1'b0, 0, 0, 4'hF));
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(2);

    $display("[TB] counting");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("run_after_start", {31'b0, running}, 32'd1);
    step(9);
    checkOutput("no_early_tick", {8'b0, time_bcd}, 32'h000000);
    step(1);
    checkOutput("first_tick", {8'b0, time_bcd}, 32'h000001);
    step(990);
    checkOutput("one_second", {8'b0, time_bcd}, 32'h000100);

    $display("[TB] pause and resume");
    step(3);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("paused", {31'b0, running}, 32'd0);
    step(20);
    checkOutput("hold_in_pause", {8'b0, time_bcd}, 32'h000100);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("resumed", {31'b0, running}, 32'd1);
    step(5);
    checkOutput("resume_pre_tick", {8'b0, time_bcd}, 32'h000100);
    step(1);
    checkOutput("resume_tick_6", {8'b0, time_bcd}, 32'h000101);

    $display("[TB] clear");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("clear_wins_running", {31'b0, running}, 32'd0);
    checkOutput("clear_wins_time", {8'b0, time_bcd}, 32'h000000);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("idle_clear_noop", {31'b0, running}, 32'd0);

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("clear_ignored_in_run", {31'b0, running}, 32'd1);
    step(8);
    checkOutput("restart_pre_tick", {8'b0, time_bcd}, 32'h000000);
    step(1);
    checkOutput("restart_tick", {8'b0, time_bcd}, 32'h000001);

    $display("[TB] wrap and snapshot");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    force dut.time_q = 24'h595999;
    #2;
    release dut.time_q;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    step(8);
    checkOutput("pre_wrap", {8'b0, time_bcd}, 32'h595999);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("wrap_time", {8'b0, time_bcd}, 32'h000000);
    checkOutput("wrap_running", {31'b0, running}, 32'd1);

    glyphAt("slot_s1",       201, 210, gexp(1'b1, 5, 10, 4'h5));
    glyphAt("slot_m1_orig",  100, 200, gexp(1'b1, 0, 0, 4'h5));
    glyphAt("slot_m0_far",   187, 279, gexp(1'b1, 39, 79, 4'h9));
    glyphAt("gap",           145, 210, gexp(1'b0, 0, 0, 4'hF));
    glyphAt("left_edge",      99, 200, gexp(1'b0, 0, 0, 4'hF));
    glyphAt("below",         100, 280, gexp(1'b0, 0, 0, 4'hF));
    glyphAt("above",         100, 199, gexp(1'b0, 0, 0, 4'hF));
    glyphAt("right_edge",    380, 200, gexp(1'b0, 0, 0, 4'hF));
    glyphAt("slot_c0_far",   379, 279, gexp(1'b1, 39, 79, 4'h9));

    step(22);
    checkOutput("midframe_time", {8'b0, time_bcd}, 32'h000003);
    checkOutput("snap_hold", gobs, gexp(1'b1, 39, 79, 4'h9));
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    step(1);
    checkOutput("snap_reload", gobs, gexp(1'b1, 39, 79, 4'h3));

`ifdef STOPWATCH_LAP_EN
    $display("[TB] lap freeze");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    step(26);
    checkOutput("lap_time_runs", {8'b0, time_bcd}, 32'h000006);
    for (int f = 0; f < 3; f++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      step(1);
      checkOutput("lap_frozen", gobs, gexp(1'b1, 39, 79, 4'h3));
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    step(1);
    checkOutput("lap_unfrozen", gobs, gexp(1'b1, 39, 79, 4'h6));
`else
    $display("[TB] lap ignored");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    step(26);
    checkOutput("lap_time_runs", {8'b0, time_bcd}, 32'h000006);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    step(1);
    checkOutput("lap_no_freeze", gobs, gexp(1'b1, 39, 79, 4'h6));
`endif

    $display("[TB] async reset");
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_running", {31'b0, running}, 32'd0);
    checkOutput("async_rst_time", {8'b0, time_bcd}, 32'h000000);
    checkOutput("async_rst_glyph", gobs, gexp(1'b0, 0, 0, 4'hF));

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
